branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Registered branch resolution stage with a parametrised 2-bit bimodal branch history table (BHT) and misprediction detection. Fetch reads the BHT for a direction prediction. Execute presents conditional branches (opcode 7'b1100011) with operands, PC, immediate and the prediction used. The block resolves all six RV32 branch conditions with correct signed/unsigned compares, trains the BHT, and returns a one-cycle-latency result with next PC, redirect flag and performance counters under a valid/ready handshake.

## Interface
- XLEN, 32: data and PC width.
- BHT_DEPTH, 64: BHT entries; power of two, minimum 2.
- CNT_W, 32: performance counter width.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pred_pc  in  XLEN  fetch PC for lookup.
- pred_taken  out  1  combinational; MSB of BHT[pred_pc[log2(BHT_DEPTH)+1:2]].
- ex_valid  in  1  execute request valid.
- ex_ready  out  1  request accepted when ex_valid && ex_ready.
- ex_opcode  in  7  instruction opcode.
- ex_funct3  in  3  branch condition.
- ex_imm  in  13  signed byte offset; bit 0 ignored (treated as 0).
- ex_rs1, ex_rs2  in  XLEN  operands.
- ex_pc  in  XLEN  branch PC.
- ex_pred_taken  in  1  prediction used by fetch for this instruction.
- flush  in  1  synchronous kill of request and held result.
- res_valid  out  1  result valid; reset 0.
- res_ready  in  1  consumer accepts result.
- res_is_branch, res_taken, res_mispredict, res_misaligned, res_illegal  out  1 each  result flags; reset 0.
- res_next_pc  out  XLEN  resolved next PC; reset 0.
- perf_branches, perf_mispredicts  out  CNT_W  saturating counters; reset 0.

## Operation
- Branch: ex_opcode == 7'b1100011. funct3 mapping:
  - 000 BEQ; 001 BNE
  - 100 BLT signed; 101 BGE signed
  - 110 BLTU unsigned; 111 BGEU unsigned
- funct3 010/011 on a branch: res_illegal=1, res_taken=0, no BHT update, no counter increment.
- target = ex_pc + sign_extend({ex_imm[12:1],1'b0}), modulo 2^XLEN. res_next_pc = taken ? target : ex_pc+4, with wrap.
- res_misaligned = taken && target[1:0] != 0.
- res_mispredict = res_taken != ex_pred_taken. This holds for non-branches too, where res_taken=0.
- Non-branch accepted: res_is_branch=0, res_taken=0, res_next_pc=ex_pc+4. No BHT or counter effect.
- BHT: 2-bit saturating counters. States 00 SNT, 01 WNT, 10 WT, 11 ST. All reset to 01.
  - On acceptance of a legal branch: index ex_pc[log2(BHT_DEPTH)+1:2]; increment if taken, else decrement; saturate at 11/00.
- Counters:
  - perf_branches increments on each accepted legal branch.
  - perf_mispredicts increments on each accepted legal branch with a mispredict.
  - Both saturate at all-ones.

## Timing
- ex_ready = !flush && (!res_valid || res_ready). Output is a single-entry register with full-throughput pass-through.
- Request accepted at edge N: result visible from N+1. Held stable while res_valid && !res_ready.
- res_valid clears at an edge where res_valid && res_ready and no new request is accepted.
- BHT and counters update at the acceptance edge.
- Simultaneous lookup and update of the same index: pred_taken shows the pre-update value that cycle and the new value from the next cycle.
- flush has priority:
  - The request that cycle is not accepted.
  - res_valid clears at the next edge.
  - No BHT or counter update.
  - BHT contents are retained.
- rst_n low at any time: all outputs and counters go to 0 and all BHT entries to 01 immediately, independent of clk. Any in-flight result is lost.

## Test plan
- Reset, pred_pc=0x100 -> pred_taken=0. Branch BEQ pc=0x100, imm=0x010, rs1=rs2=5, pred=0 -> next cycle res_taken=1, res_next_pc=0x110, res_mispredict=1, perf_mispredicts=1.
- BLT rs1=0xFFFFFFFF, rs2=1 -> taken. BLTU with the same operands -> not taken, res_next_pc=pc+4. BGE/BGEU give the complementary results.
- Three taken branches at pc=0x40 -> BHT entry goes 01->10->11->11; pred_taken=1 after the first. Four not-taken branches -> 11->10->01->00->00.
- res_ready=0 for 3 cycles with ex_valid=1 -> ex_ready=0, result held constant, BHT updated once. Then res_ready=1 -> next request accepted the same cycle.
- funct3=010 -> res_illegal=1, counters unchanged. imm=0x002 taken -> res_misaligned=1. pc=0xFFFFFFFC not taken -> res_next_pc=0.
- flush while res_valid=1 and ex_valid=1 -> res_valid=0 next cycle, no update. rst_n pulsed low mid-stall -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: resolves RV32 conditional branches, trains a 2-bit
// bimodal history table and returns a registered result with perf counters.
module branch_resolve_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  pred_pc,
    output logic             pred_taken,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [6:0]       ex_opcode,
    input  logic [2:0]       ex_funct3,
    input  logic [12:0]      ex_imm,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic [XLEN-1:0]  ex_rs2,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_pred_taken,
    input  logic             flush,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_is_branch,
    output logic             res_taken,
    output logic             res_mispredict,
    output logic             res_misaligned,
    output logic             res_illegal,
    output logic [XLEN-1:0]  res_next_pc,
    output logic [CNT_W-1:0] perf_branches,
    output logic [CNT_W-1:0] perf_mispredicts
);
    localparam int         IDX_W      = $clog2(BHT_DEPTH);
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    function automatic logic [1:0] bht_train(input logic [1:0] s, input logic taken);
        if (taken) return (s == 2'b11) ? s : s + 2'b01;
        else       return (s == 2'b00) ? s : s - 2'b01;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic [1:0]       bht_q [BHT_DEPTH];
    logic [1:0]       bht_d [BHT_DEPTH];
    logic             res_valid_q, res_valid_d;
    logic             res_is_branch_q, res_is_branch_d;
    logic             res_taken_q, res_taken_d;
    logic             res_mispredict_q, res_mispredict_d;
    logic             res_misaligned_q, res_misaligned_d;
    logic             res_illegal_q, res_illegal_d;
    logic [XLEN-1:0]  res_next_pc_q, res_next_pc_d;
    logic [CNT_W-1:0] perf_branches_q, perf_branches_d;
    logic [CNT_W-1:0] perf_mispredicts_q, perf_mispredicts_d;

    logic signed [XLEN-1:0] rs1_s, rs2_s;
    logic [XLEN-1:0]        imm_ext, target, seq_pc;
    logic                   is_branch, illegal, legal_branch, cond, taken, mispredict, accept;
    logic [IDX_W-1:0]       ex_idx, pred_idx;
    logic                   unused_ok;

    assign pred_idx   = pred_pc[IDX_W+1:2];
    assign ex_idx     = ex_pc[IDX_W+1:2];
    assign pred_taken = bht_q[pred_idx][1];
    assign unused_ok  = ^{pred_pc, ex_imm[0]};

    assign ex_ready = !flush && (!res_valid_q || res_ready);
    assign accept   = ex_valid && ex_ready;

    assign rs1_s   = ex_rs1;
    assign rs2_s   = ex_rs2;
    assign imm_ext = {{(XLEN-12){ex_imm[12]}}, ex_imm[11:1], 1'b0};
    assign target  = ex_pc + imm_ext;
    assign seq_pc  = ex_pc + XLEN'(4);

    assign is_branch    = (ex_opcode == OPC_BRANCH);
    assign illegal      = is_branch && (ex_funct3[2:1] == 2'b01);
    assign legal_branch = is_branch && !illegal;

    always_comb begin
        cond = 1'b0;
        case (ex_funct3)
            3'b000:  cond = (ex_rs1 == ex_rs2);
            3'b001:  cond = (ex_rs1 != ex_rs2);
            3'b100:  cond = (rs1_s < rs2_s);
            3'b101:  cond = (rs1_s >= rs2_s);
            3'b110:  cond = (ex_rs1 < ex_rs2);
            3'b111:  cond = (ex_rs1 >= ex_rs2);
            default: cond = 1'b0;
        endcase
    end

    assign taken      = legal_branch && cond;
    assign mispredict = (taken != ex_pred_taken);

    always_comb begin
        res_valid_d        = res_valid_q;
        res_is_branch_d    = res_is_branch_q;
        res_taken_d        = res_taken_q;
        res_mispredict_d   = res_mispredict_q;
        res_misaligned_d   = res_misaligned_q;
        res_illegal_d      = res_illegal_q;
        res_next_pc_d      = res_next_pc_q;
        perf_branches_d    = perf_branches_q;
        perf_mispredicts_d = perf_mispredicts_q;
        bht_d              = bht_q;

        if (flush) begin
            res_valid_d = 1'b0;
        end else if (accept) begin
            res_valid_d      = 1'b1;
            res_is_branch_d  = is_branch;
            res_taken_d      = taken;
            res_mispredict_d = mispredict;
            res_misaligned_d = taken && (target[1:0] != 2'b00);
            res_illegal_d    = illegal;
            res_next_pc_d    = taken ? target : seq_pc;
            if (legal_branch) begin
                bht_d[ex_idx]   = bht_train(bht_q[ex_idx], taken);
                perf_branches_d = sat_inc(perf_branches_q);
                if (mispredict) perf_mispredicts_d = sat_inc(perf_mispredicts_q);
            end
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q        <= 1'b0;
            res_is_branch_q    <= 1'b0;
            res_taken_q        <= 1'b0;
            res_mispredict_q   <= 1'b0;
            res_misaligned_q   <= 1'b0;
            res_illegal_q      <= 1'b0;
            res_next_pc_q      <= '0;
            perf_branches_q    <= '0;
            perf_mispredicts_q <= '0;
            for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
        end else begin
            res_valid_q        <= res_valid_d;
            res_is_branch_q    <= res_is_branch_d;
            res_taken_q        <= res_taken_d;
            res_mispredict_q   <= res_mispredict_d;
            res_misaligned_q   <= res_misaligned_d;
            res_illegal_q      <= res_illegal_d;
            res_next_pc_q      <= res_next_pc_d;
            perf_branches_q    <= perf_branches_d;
            perf_mispredicts_q <= perf_mispredicts_d;
            bht_q              <= bht_d;
        end
    end

    assign res_valid        = res_valid_q;
    assign res_is_branch    = res_is_branch_q;
    assign res_taken        = res_taken_q;
    assign res_mispredict   = res_mispredict_q;
    assign res_misaligned   = res_misaligned_q;
    assign res_illegal      = res_illegal_q;
    assign res_next_pc      = res_next_pc_q;
    assign perf_branches    = perf_branches_q;
    assign perf_mispredicts = perf_mispredicts_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed-vector bench for branch_resolve_unit with hand-computed expectations.
module tb_branch_resolve_unit;
    localparam logic [6:0] BR = 7'b1100011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pred_pc = 32'h0;
    logic        pred_taken;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [6:0]  ex_opcode = 7'h0;
    logic [2:0]  ex_funct3 = 3'h0;
    logic [12:0] ex_imm = 13'h0;
    logic [31:0] ex_rs1 = 32'h0, ex_rs2 = 32'h0, ex_pc = 32'h0;
    logic        ex_pred_taken = 1'b0;
    logic        flush = 1'b0;
    logic        res_valid, res_ready = 1'b1;
    logic        res_is_branch, res_taken, res_mispredict, res_misaligned, res_illegal;
    logic [31:0] res_next_pc, perf_branches, perf_mispredicts;
    logic [5:0]  flags;

    int vectors = 0;
    int miscompares = 0;

    branch_resolve_unit #(.XLEN(32), .BHT_DEPTH(64), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode),
        .ex_funct3(ex_funct3), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken), .flush(flush),
        .res_valid(res_valid), .res_ready(res_ready), .res_is_branch(res_is_branch),
        .res_taken(res_taken), .res_mispredict(res_mispredict),
        .res_misaligned(res_misaligned), .res_illegal(res_illegal),
        .res_next_pc(res_next_pc), .perf_branches(perf_branches),
        .perf_mispredicts(perf_mispredicts)
    );

    always #5 clk = ~clk;

    // {valid, is_branch, taken, mispredict, misaligned, illegal}
    assign flags = {res_valid, res_is_branch, res_taken, res_mispredict, res_misaligned, res_illegal};

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [12:0] imm,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                         input logic pr);
        ex_valid = 1'b1; ex_opcode = opc; ex_funct3 = f3; ex_imm = imm;
        ex_rs1 = a; ex_rs2 = b; ex_pc = pc; ex_pred_taken = pr;
    endtask

    task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [12:0] imm,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                         input logic pr);
        drive(opc, f3, imm, a, b, pc, pr);
        @(posedge clk); #1;
        ex_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        pred_pc = 32'h100;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (flags !== 6'b0) begin miscompares++; $display("FAIL reset_flags: got %b want %b", flags, 6'b0); end
        vectors++;
        if ({res_next_pc, perf_branches, perf_mispredicts} !== 96'h0) begin
            miscompares++; $display("FAIL reset_regs: got %h %h %h want 0", res_next_pc, perf_branches, perf_mispredicts);
        end
        vectors++;
        if (pred_taken !== 1'b0) begin miscompares++; $display("FAIL reset_pred: got %b want 0", pred_taken); end
        #2 rst_n = 1'b1;
        idle();
    endtask

    task automatic test_beq();
        issue(BR, 3'b000, 13'h010, 32'd5, 32'd5, 32'h100, 1'b0);
        vectors++;
        if (flags !== 6'b111100) begin miscompares++; $display("FAIL beq_flags: got %b want %b", flags, 6'b111100); end
        vectors++;
        if (res_next_pc !== 32'h110) begin miscompares++; $display("FAIL beq_pc: got %h want %h", res_next_pc, 32'h110); end
        vectors++;
        if ({perf_branches, perf_mispredicts} !== {32'd1, 32'd1}) begin
            miscompares++; $display("FAIL beq_perf: got %0d/%0d want 1/1", perf_branches, perf_mispredicts);
        end
        idle();
    endtask

    task automatic test_compares();
        issue(BR, 3'b100, 13'h020, 32'hFFFFFFFF, 32'd1, 32'h200, 1'b1);
        vectors++;
        if ({res_taken, res_next_pc} !== {1'b1, 32'h220}) begin miscompares++; $display("FAIL blt: got %b %h want 1 00000220", res_taken, res_next_pc); end
        issue(BR, 3'b110, 13'h020, 32'hFFFFFFFF, 32'd1, 32'h200, 1'b0);
        vectors++;
        if ({res_taken, res_next_pc} !== {1'b0, 32'h204}) begin miscompares++; $display("FAIL bltu: got %b %h want 0 00000204", res_taken, res_next_pc); end
        issue(BR, 3'b101, 13'h020, 32'hFFFFFFFF, 32'd1, 32'h200, 1'b0);
        vectors++;
        if ({res_taken, res_next_pc} !== {1'b0, 32'h204}) begin miscompares++; $display("FAIL bge: got %b %h want 0 00000204", res_taken, res_next_pc); end
        issue(BR, 3'b111, 13'h020, 32'hFFFFFFFF, 32'd1, 32'h200, 1'b1);
        vectors++;
        if ({res_taken, res_next_pc} !== {1'b1, 32'h220}) begin miscompares++; $display("FAIL bgeu: got %b %h want 1 00000220", res_taken, res_next_pc); end
        issue(BR, 3'b001, 13'h020, 32'd5, 32'd5, 32'h200, 1'b1);
        vectors++;
        if ({res_taken, res_mispredict} !== 2'b01) begin miscompares++; $display("FAIL bne: got %b want 01", {res_taken, res_mispredict}); end
        vectors++;
        if ({perf_branches, perf_mispredicts} !== {32'd6, 32'd2}) begin
            miscompares++; $display("FAIL cmp_perf: got %0d/%0d want 6/2", perf_branches, perf_mispredicts);
        end
        idle();
    endtask

    task automatic test_bht_train();
        logic exp_t [3] = '{1'b1, 1'b1, 1'b1};
        logic exp_n [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        pred_pc = 32'h40;
        #1;
        drive(BR, 3'b000, 13'h010, 32'd1, 32'd1, 32'h40, 1'b1);
        #1;
        vectors++;
        if (pred_taken !== 1'b0) begin miscompares++; $display("FAIL bht_same_cycle: got %b want 0", pred_taken); end
        @(posedge clk); #1;
        ex_valid = 1'b0;
        vectors++;
        if (pred_taken !== exp_t[0]) begin miscompares++; $display("FAIL bht_t0: got %b want %b", pred_taken, exp_t[0]); end
        for (int i = 1; i < 3; i++) begin
            issue(BR, 3'b000, 13'h010, 32'd1, 32'd1, 32'h40, 1'b1);
            vectors++;
            if (pred_taken !== exp_t[i]) begin miscompares++; $display("FAIL bht_t%0d: got %b want %b", i, pred_taken, exp_t[i]); end
        end
        for (int i = 0; i < 4; i++) begin
            issue(BR, 3'b001, 13'h010, 32'd1, 32'd1, 32'h40, 1'b0);
            vectors++;
            if (pred_taken !== exp_n[i]) begin miscompares++; $display("FAIL bht_n%0d: got %b want %b", i, pred_taken, exp_n[i]); end
        end
        vectors++;
        if ({perf_branches, perf_mispredicts} !== {32'd13, 32'd2}) begin
            miscompares++; $display("FAIL bht_perf: got %0d/%0d want 13/2", perf_branches, perf_mispredicts);
        end
        idle();
    endtask

    task automatic test_stall();
        pred_pc = 32'h80;
        res_ready = 1'b0;
        issue(BR, 3'b000, 13'h040, 32'd7, 32'd7, 32'h80, 1'b0);
        drive(BR, 3'b001, 13'h040, 32'd5, 32'd5, 32'h300, 1'b0);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({ex_ready, flags, res_next_pc, perf_branches} !== {1'b0, 6'b111100, 32'hC0, 32'd14}) begin
                miscompares++;
                $display("FAIL stall_hold%0d: got rdy=%b flags=%b pc=%h br=%0d want rdy=0 flags=111100 pc=000000c0 br=14",
                         i, ex_ready, flags, res_next_pc, perf_branches);
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (pred_taken !== 1'b1) begin miscompares++; $display("FAIL stall_bht: got %b want 1", pred_taken); end
        res_ready = 1'b1;
        #1;
        vectors++;
        if (ex_ready !== 1'b1) begin miscompares++; $display("FAIL stall_release_ready: got %b want 1", ex_ready); end
        @(posedge clk); #1;
        ex_valid = 1'b0;
        vectors++;
        if ({flags, res_next_pc} !== {6'b110000, 32'h304}) begin
            miscompares++; $display("FAIL stall_next: got %b %h want 110000 00000304", flags, res_next_pc);
        end
        vectors++;
        if ({perf_branches, perf_mispredicts} !== {32'd15, 32'd3}) begin
            miscompares++; $display("FAIL stall_perf: got %0d/%0d want 15/3", perf_branches, perf_mispredicts);
        end
        idle();
        vectors++;
        if (res_valid !== 1'b0) begin miscompares++; $display("FAIL stall_drain: got %b want 0", res_valid); end
    endtask

    task automatic test_corner_cases();
        issue(BR, 3'b010, 13'h010, 32'd1, 32'd1, 32'h400, 1'b0);
        vectors++;
        if ({flags, res_next_pc, perf_branches, perf_mispredicts} !== {6'b110001, 32'h404, 32'd15, 32'd3}) begin
            miscompares++; $display("FAIL illegal: got %b %h %0d/%0d want 110001 00000404 15/3", flags, res_next_pc, perf_branches, perf_mispredicts);
        end
        issue(BR, 3'b000, 13'h002, 32'd1, 32'd1, 32'h500, 1'b1);
        vectors++;
        if ({flags, res_next_pc} !== {6'b111010, 32'h502}) begin
            miscompares++; $display("FAIL misaligned: got %b %h want 111010 00000502", flags, res_next_pc);
        end
        issue(BR, 3'b001, 13'h010, 32'd1, 32'd1, 32'hFFFFFFFC, 1'b0);
        vectors++;
        if ({res_taken, res_next_pc} !== {1'b0, 32'h0}) begin miscompares++; $display("FAIL wrap: got %b %h want 0 00000000", res_taken, res_next_pc); end
        issue(7'b0110011, 3'b000, 13'h010, 32'd1, 32'd1, 32'h600, 1'b1);
        vectors++;
        if ({flags, res_next_pc, perf_branches, perf_mispredicts} !== {6'b100100, 32'h604, 32'd17, 32'd3}) begin
            miscompares++; $display("FAIL nonbranch: got %b %h %0d/%0d want 100100 00000604 17/3", flags, res_next_pc, perf_branches, perf_mispredicts);
        end
        issue(BR, 3'b000, 13'h1FF0, 32'd9, 32'd9, 32'h100, 1'b1);
        vectors++;
        if ({res_taken, res_next_pc} !== {1'b1, 32'hF0}) begin miscompares++; $display("FAIL neg_imm: got %b %h want 1 000000f0", res_taken, res_next_pc); end
        idle();
    endtask

    task automatic test_flush();
        pred_pc = 32'h80;
        issue(BR, 3'b000, 13'h010, 32'd3, 32'd3, 32'h600, 1'b0);
        drive(BR, 3'b001, 13'h010, 32'd3, 32'd3, 32'h80, 1'b1);
        flush = 1'b1;
        #1;
        vectors++;
        if ({res_valid, ex_ready} !== 2'b10) begin miscompares++; $display("FAIL flush_ready: got %b want 10", {res_valid, ex_ready}); end
        @(posedge clk); #1;
        flush = 1'b0; ex_valid = 1'b0;
        vectors++;
        if ({res_valid, perf_branches, perf_mispredicts} !== {1'b0, 32'd19, 32'd4}) begin
            miscompares++; $display("FAIL flush_kill: got %b %0d/%0d want 0 19/4", res_valid, perf_branches, perf_mispredicts);
        end
        vectors++;
        if (pred_taken !== 1'b1) begin miscompares++; $display("FAIL flush_bht: got %b want 1", pred_taken); end
        idle();
    endtask

    task automatic test_async_reset();
        pred_pc = 32'h80;
        res_ready = 1'b0;
        issue(BR, 3'b000, 13'h010, 32'd3, 32'd3, 32'h700, 1'b0);
        drive(BR, 3'b000, 13'h010, 32'd3, 32'd3, 32'h704, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if ({flags, res_next_pc, perf_branches, perf_mispredicts, pred_taken} !== 103'h0) begin
            miscompares++; $display("FAIL async_reset: got %b %h %0d/%0d pred=%b want all 0", flags, res_next_pc, perf_branches, perf_mispredicts, pred_taken);
        end
        ex_valid = 1'b0; res_ready = 1'b1;
        #2 rst_n = 1'b1;
        idle();
    endtask

    initial begin
        test_reset();
        test_beq();
        test_compares();
        test_bht_train();
        test_stall();
        test_corner_cases();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
